sprite_motion_ctrl: RTL and testbench

Per-frame motion scheduler for the VGA game sprite chain. Holds position and velocity for up to N sprites, detects the start of vertical blanking from the VGA timing counters, and advances each sprite by its velocity, bouncing off the screen edges. It drives the `block_posx`/`block_posy` inputs of the chained circle-sprite renderers. Outputs change only during blanking, so each rendered frame sees a consistent set of positions.

---
 rtl/vga_game_pkg.sv | 8 +
 rtl/bounce_axis.sv | 26 ++
 rtl/sprite_motion_ctrl.sv | 112 +++++++++++
 tb/tb_sprite_motion_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_game_pkg.sv
// vga_game_pkg: screen geometry, datapath widths and motion FSM encoding shared by the VGA game blocks.
package vga_game_pkg;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int POS_W = 16;
    localparam int VEL_W = 8;
    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;
endpackage

// File: rtl/bounce_axis.sv
// bounce_axis: one-axis position step with single reflection off the [0, max] walls.
module bounce_axis
    import vga_game_pkg::*;
(
    input  logic [POS_W-1:0] p,
    input  logic [VEL_W-1:0] v,
    input  logic [POS_W-1:0] max,
    input  logic             run,
    output logic [POS_W-1:0] p_n,
    output logic [VEL_W-1:0] v_n,
    output logic             hit
);
    logic signed [POS_W:0] n, m, r;
    logic lo, hi;
    always_comb begin
        m   = $signed({1'b0, max});
        n   = run ? $signed({1'b0, p}) + $signed({{(POS_W+1-VEL_W){v[VEL_W-1]}}, v}) : $signed({1'b0, p});
        lo  = n < 0;
        hi  = n > m;
        r   = lo ? -n : hi ? (m <<< 1) - n : n;
        p_n = r[POS_W-1:0];
        hit = lo | hi;
        // -128 has no positive counterpart in 8 bits, so reflect it to +127
        v_n = hit ? ((v == {1'b1, {(VEL_W-1){1'b0}}}) ? {1'b0, {(VEL_W-1){1'b1}}} : -v) : v;
    end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame sprite position/velocity update during vertical blanking,
// committing a consistent snapshot of positions to the renderer chain.
module sprite_motion_ctrl
    import vga_game_pkg::*;
#(
    parameter int N_SPRITES = 2,
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 600,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 32
) (
    input  logic                   clk50,
    input  logic                   rst,
    input  logic [10:0]            hst,
    input  logic [9:0]             vst,
    input  logic                   run,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [2:0]             cfg_idx,
    input  logic [15:0]            cfg_posx,
    input  logic [15:0]            cfg_posy,
    input  logic [7:0]             cfg_vx,
    input  logic [7:0]             cfg_vy,
    output logic [16*N_SPRITES-1:0] posx_o,
    output logic [16*N_SPRITES-1:0] posy_o,
    output logic [N_SPRITES-1:0]   hit_o,
    output logic                   frame_tick
);
    localparam int IW = N_SPRITES > 1 ? $clog2(N_SPRITES) : 1;
    localparam logic [POS_W-1:0] MAX_X = POS_W'(H_ACTIVE - SPRITE_W);
    localparam logic [POS_W-1:0] MAX_Y = POS_W'(V_ACTIVE - SPRITE_H);

    state_t state, state_n;
    logic [IW-1:0] idx, ci;
    logic [POS_W-1:0] px [N_SPRITES];
    logic [POS_W-1:0] py [N_SPRITES];
    logic [VEL_W-1:0] vx [N_SPRITES];
    logic [VEL_W-1:0] vy [N_SPRITES];
    logic [N_SPRITES-1:0] hit;
    logic [POS_W-1:0] px_n, py_n;
    logic [VEL_W-1:0] vx_n, vy_n;
    logic hx, hy, frame_start, cfg_wr;

    assign frame_start = hst == 11'd0 && vst == 10'(V_ACTIVE);
    assign ci = cfg_idx[IW-1:0];
    assign cfg_wr = cfg_valid && cfg_ready && int'(cfg_idx) < N_SPRITES;

    bounce_axis u_x (.p(px[idx]), .v(vx[idx]), .max(MAX_X), .run(run), .p_n(px_n), .v_n(vx_n), .hit(hx));
    bounce_axis u_y (.p(py[idx]), .v(vy[idx]), .max(MAX_Y), .run(run), .p_n(py_n), .v_n(vy_n), .hit(hy));

    always_ff @(posedge clk50) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= state == CALC ? idx + 1'b1 : '0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = frame_start ? CALC : IDLE;
            CALC:    state_n = idx == IW'(N_SPRITES - 1) ? COMMIT : CALC;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready  = state == IDLE;
        frame_tick = state == COMMIT;
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                px[i] <= '0;
                py[i] <= '0;
                vx[i] <= '0;
                vy[i] <= '0;
            end
            hit    <= '0;
            posx_o <= '0;
            posy_o <= '0;
            hit_o  <= '0;
        end else begin
            // a write taken on the frame-start cycle lands before CALC reads it
            if (cfg_wr) begin
                px[ci]  <= cfg_posx > MAX_X ? MAX_X : cfg_posx;
                py[ci]  <= cfg_posy > MAX_Y ? MAX_Y : cfg_posy;
                vx[ci]  <= cfg_vx;
                vy[ci]  <= cfg_vy;
                hit[ci] <= 1'b0;
            end
            if (state == CALC) begin
                px[idx]  <= px_n;
                py[idx]  <= py_n;
                vx[idx]  <= vx_n;
                vy[idx]  <= vy_n;
                hit[idx] <= hx | hy;
            end
            if (state == COMMIT) begin
                for (int i = 0; i < N_SPRITES; i++) begin
                    posx_o[16*i +: 16] <= px[i];
                    posy_o[16*i +: 16] <= py[i];
                end
                hit_o <= hit;
            end
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: scenario tasks plus randomized frames checked against a bounce model.
module tb_sprite_motion_ctrl;
    localparam int N = 2;
    localparam int MX = 768;
    localparam int MY = 568;

    logic clk50 = 0, rst = 1, run = 0, cfg_valid = 0;
    logic [10:0] hst = 11'd5;
    logic [9:0] vst = 10'd0;
    logic [2:0] cfg_idx = 0;
    logic [15:0] cfg_posx = 0, cfg_posy = 0;
    logic [7:0] cfg_vx = 0, cfg_vy = 0;
    logic cfg_ready, frame_tick;
    logic [16*N-1:0] posx_o, posy_o;
    logic [N-1:0] hit_o;

    int total = 0, bad = 0;
    int mpx[N], mpy[N], mvx[N], mvy[N];
    bit mhit[N];

    sprite_motion_ctrl #(.N_SPRITES(N)) dut (
        .clk50(clk50), .rst(rst), .hst(hst), .vst(vst), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_posx(cfg_posx), .cfg_posy(cfg_posy), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
        .posx_o(posx_o), .posy_o(posy_o), .hit_o(hit_o), .frame_tick(frame_tick)
    );

    always #10 clk50 = ~clk50;

    task automatic tick;
        @(posedge clk50);
        #1;
    endtask

    function automatic void axis(inout int p, inout int v, input int mx, input bit r, output bit h);
        int n;
        n = r ? p + v : p;
        h = 0;
        if (n < 0) begin p = -n; h = 1; end
        else if (n > mx) begin p = 2 * mx - n; h = 1; end
        else p = n;
        if (h) v = (v == -128) ? 127 : -v;
    endfunction

    function automatic void model_frame(input bit r);
        for (int i = 0; i < N; i++) begin
            int p, v;
            bit hx, hy;
            p = mpx[i]; v = mvx[i]; axis(p, v, MX, r, hx); mpx[i] = p; mvx[i] = v;
            p = mpy[i]; v = mvy[i]; axis(p, v, MY, r, hy); mpy[i] = p; mvy[i] = v;
            mhit[i] = hx | hy;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mpx[i] = 0; mpy[i] = 0; mvx[i] = 0; mvy[i] = 0; mhit[i] = 0;
        end
    endfunction

    task automatic drive_cfg(input int idx, input int x, input int y, input int vx, input int vy);
        cfg_idx = 3'(idx); cfg_posx = 16'(x); cfg_posy = 16'(y); cfg_vx = 8'(vx); cfg_vy = 8'(vy);
        if (idx < N) begin
            mpx[idx] = x > MX ? MX : x;
            mpy[idx] = y > MY ? MY : y;
            mvx[idx] = int'($signed(8'(vx)));
            mvy[idx] = int'($signed(8'(vy)));
            mhit[idx] = 0;
        end
    endtask

    task automatic cfg_write(input int idx, input int x, input int y, input int vx, input int vy);
        drive_cfg(idx, x, y, vx, vy);
        cfg_valid = 1;
        tick();
        cfg_valid = 0;
    endtask

    task automatic check_outputs(input string name);
        for (int i = 0; i < N; i++) begin
            total++;
            if (posx_o[16*i +: 16] !== 16'(mpx[i]) || posy_o[16*i +: 16] !== 16'(mpy[i]) || hit_o[i] !== mhit[i]) begin
                bad++;
                $display("FAIL %s sprite%0d got x=%0d y=%0d hit=%b required x=%0d y=%0d hit=%b", name, i,
                         posx_o[16*i +: 16], posy_o[16*i +: 16], hit_o[i], mpx[i], mpy[i], mhit[i]);
            end
        end
    endtask

    // frame start for one cycle, then check CALC/COMMIT timing and the committed outputs
    task automatic do_frame(input bit with_cfg, input string name);
        model_frame(run);
        hst = 11'd0; vst = 10'd600;
        if (with_cfg) cfg_valid = 1;
        tick();
        hst = 11'd5; vst = 10'd601; cfg_valid = 0;
        for (int k = 0; k < N; k++) begin
            total++;
            if (cfg_ready !== 1'b0 || frame_tick !== 1'b0) begin
                bad++;
                $display("FAIL %s calc_cycle%0d ready=%b tick=%b required 0 0", name, k, cfg_ready, frame_tick);
            end
            tick();
        end
        total++;
        if (frame_tick !== 1'b1 || cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s commit_cycle tick=%b ready=%b required 1 0", name, frame_tick, cfg_ready);
        end
        tick();
        total++;
        if (frame_tick !== 1'b0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_return tick=%b ready=%b required 0 1", name, frame_tick, cfg_ready);
        end
        check_outputs(name);
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) tick();
        rst = 0;
        model_reset();
        total++;
        if (cfg_ready !== 1'b1 || frame_tick !== 1'b0 || posx_o !== '0 || posy_o !== '0 || hit_o !== '0) begin
            bad++;
            $display("FAIL reset_state ready=%b tick=%b posx=%h posy=%h hit=%b required 1 0 0 0 0",
                     cfg_ready, frame_tick, posx_o, posy_o, hit_o);
        end
        for (int k = 0; k < 200; k++) begin
            hst = 11'(k); vst = 10'(k % 600);
            tick();
            if (frame_tick !== 1'b0) begin
                total++; bad++;
                $display("FAIL reset_no_tick cycle=%0d tick=%b required 0", k, frame_tick);
            end
        end
        hst = 11'd5; vst = 10'd0;
    endtask

    task automatic test_simple_motion;
        run = 1;
        cfg_write(0, 100, 100, 5, -3);
        do_frame(0, "simple");
        total++;
        if (posx_o[15:0] !== 16'd105 || posy_o[15:0] !== 16'd97 || hit_o !== '0) begin
            bad++;
            $display("FAIL simple_const got x=%0d y=%0d hit=%b required 105 97 00", posx_o[15:0], posy_o[15:0], hit_o);
        end
    endtask

    task automatic test_right_edge;
        cfg_write(1, 765, 300, 10, 0);
        do_frame(0, "right1");
        total++;
        if (posx_o[31:16] !== 16'd761 || hit_o[1] !== 1'b1) begin
            bad++;
            $display("FAIL right1_const got x=%0d hit=%b required 761 1", posx_o[31:16], hit_o[1]);
        end
        do_frame(0, "right2");
        total++;
        if (posx_o[31:16] !== 16'd751 || hit_o[1] !== 1'b0) begin
            bad++;
            $display("FAIL right2_const got x=%0d hit=%b required 751 0", posx_o[31:16], hit_o[1]);
        end
    endtask

    task automatic test_top_edge;
        cfg_write(0, 50, 2, 0, -5);
        do_frame(0, "top1");
        total++;
        if (posy_o[15:0] !== 16'd3 || hit_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL top1_const got y=%0d hit=%b required 3 1", posy_o[15:0], hit_o[0]);
        end
        do_frame(0, "top2");
        total++;
        if (posy_o[15:0] !== 16'd8 || hit_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL top2_const got y=%0d hit=%b required 8 0", posy_o[15:0], hit_o[0]);
        end
    endtask

    task automatic test_freeze_clamp;
        run = 0;
        cfg_write(0, 2000, 900, 7, -9);
        for (int f = 0; f < 3; f++) begin
            do_frame(0, "freeze");
            total++;
            if (posx_o[15:0] !== 16'd768 || posy_o[15:0] !== 16'd568) begin
                bad++;
                $display("FAIL freeze_const frame=%0d got x=%0d y=%0d required 768 568", f, posx_o[15:0], posy_o[15:0]);
            end
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 30; f++) begin
            run = $urandom_range(0, 3) != 0;
            for (int w = $urandom_range(0, 2); w > 0; w--)
                cfg_write($urandom_range(0, 7), $urandom_range(0, 1100), $urandom_range(0, 900),
                          $urandom_range(0, 255), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                drive_cfg($urandom_range(0, N - 1), $urandom_range(0, 800), $urandom_range(0, 600),
                          $urandom_range(0, 1) ? 128 : $urandom_range(0, 255), $urandom_range(0, 255));
                do_frame(1, "random_samecycle");
            end else begin
                do_frame(0, "random");
            end
        end
    endtask

    task automatic test_handshake;
        bit done;
        run = 1;
        hst = 11'd0; vst = 10'd600;
        model_frame(run);
        tick();
        hst = 11'd5; vst = 10'd601;
        cfg_idx = 3'd1; cfg_posx = 16'd400; cfg_posy = 16'd200; cfg_vx = 8'd3; cfg_vy = 8'd4;
        cfg_valid = 1;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            if (cfg_ready === 1'b1) done = 1;
            else tick();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL handshake_timeout ready=%b required 1", cfg_ready);
        end
        tick();
        cfg_valid = 0;
        drive_cfg(1, 400, 200, 3, 4);
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake_ready_after ready=%b required 1", cfg_ready);
        end
        do_frame(0, "handshake");
    endtask

    task automatic test_reset_mid_calc;
        run = 1;
        cfg_write(0, 300, 300, 4, 4);
        do_frame(0, "pre_reset");
        hst = 11'd0; vst = 10'd600;
        tick();
        hst = 11'd5; vst = 10'd601;
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        total++;
        if (posx_o !== '0 || posy_o !== '0 || hit_o !== '0 || frame_tick !== 1'b0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_calc posx=%h posy=%h hit=%b tick=%b ready=%b required 0 0 0 0 1",
                     posx_o, posy_o, hit_o, frame_tick, cfg_ready);
        end
        for (int k = 0; k < 2 * N + 2; k++) begin
            tick();
            if (frame_tick !== 1'b0) begin
                total++; bad++;
                $display("FAIL reset_mid_calc_tick cycle=%0d tick=%b required 0", k, frame_tick);
            end
        end
        do_frame(0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_simple_motion();
        test_right_edge();
        test_top_edge();
        test_freeze_clamp();
        test_random();
        test_handshake();
        test_reset_mid_calc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
